mips_mem_responder: RTL

MIPS_MEM_RESPONDER -- requirements
Module: mips_mem_responder

---
 rtl/mips_mem_responder_pkg.sv | 14 +
 rtl/mips_mem_responder_mem_array.sv | 24 ++
 rtl/mips_mem_responder.sv | 105 ++++++++++
 3 files changed

// File: rtl/mips_mem_responder_pkg.sv
// Shared definitions for the MIPS memory responder: FSM encoding and the
// fill bit used to build the default memory-mapped I/O address.
package mips_mem_responder_pkg;

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int   DEFAULT_WIDTH = 8;
    // The default I/O address is the all-ones address at any data width.
    localparam logic IOADR_FILL    = 1'b1;

endpackage

// File: rtl/mips_mem_responder_mem_array.sv
// Single-port word array: synchronous write, asynchronous read at the same address.
module mem_array #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             we,
    input  logic [WIDTH-1:0] addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    localparam int DEPTH = 1 << WIDTH;

    logic [WIDTH-1:0] mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mips_mem_responder.sv
// Memory responder for a small MIPS core: boots the array from a byte loader
// while holding the core in reset, then serves core reads/writes plus one I/O port.
module mips_mem_responder
    import mips_mem_responder_pkg::*;
#(
    parameter int               WIDTH = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] IOADR = {WIDTH{IOADR_FILL}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             memread,
    input  logic             memwrite,
    input  logic [WIDTH-1:0] adr,
    input  logic [WIDTH-1:0] writedata,
    output logic [WIDTH-1:0] memdata,
    output logic             cpu_reset,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_last,
    output logic             load_ready,
    input  logic [WIDTH-1:0] io_in,
    output logic [WIDTH-1:0] io_out,
    output logic             io_strobe,
    output state_t           dbg_state_o
);

    // Loader handshake: a byte transfers on a rising edge where
    // load_valid and load_ready are both high; load_last is only
    // meaningful while load_valid is high.

    state_t           state_q;
    logic [WIDTH-1:0] cnt_q;
    logic             cpu_reset_q;
    logic [WIDTH-1:0] io_out_q;
    logic             io_strobe_q;

    logic             run;
    logic             is_io;
    logic             load_fire;
    logic             mem_we;
    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic [WIDTH-1:0] mem_rdata;

    assign run       = (state_q == ST_RUN);
    assign is_io     = (adr == IOADR);
    assign load_fire = !run && load_valid;

    // The array has one port, so the loader owns it in LOAD and the core in RUN.
    assign mem_we    = load_fire || (run && memwrite && !is_io);
    assign mem_addr  = run ? adr : cnt_q;
    assign mem_wdata = run ? writedata : load_data;

    mem_array #(
        .WIDTH (WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_LOAD;
            cnt_q       <= '0;
            cpu_reset_q <= 1'b1;
            io_out_q    <= '0;
            io_strobe_q <= 1'b0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    io_strobe_q <= 1'b0;
                    if (load_valid) begin
                        cnt_q <= cnt_q + WIDTH'(1);
                        // A full array ends loading even without load_last.
                        if (load_last || (cnt_q == {WIDTH{1'b1}})) begin
                            state_q     <= ST_RUN;
                            cpu_reset_q <= 1'b0;
                        end
                    end
                end
                ST_RUN: begin
                    io_strobe_q <= memwrite && is_io;
                    if (memwrite && is_io) begin
                        io_out_q <= writedata;
                    end
                end
                default: begin
                    state_q     <= ST_LOAD;
                    cpu_reset_q <= 1'b1;
                end
            endcase
        end
    end

    assign memdata     = (run && memread) ? (is_io ? io_in : mem_rdata) : '0;
    assign load_ready  = !run;
    assign cpu_reset   = cpu_reset_q;
    assign io_out      = io_out_q;
    assign io_strobe   = io_strobe_q;
    assign dbg_state_o = state_q;

endmodule
